// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - circular-buffer sample FIFO with registered output word and overflow tracking
// Define SAMPLE_FIFO_OVF_CNT_EN to implement the 16-bit saturating dropped-word counter on ovf_cnt.
module sample_fifo #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                rd_ready,
    input  logic                clr_ovf,
    output logic                rd_valid,
    output logic [DATA_LEN-1:0] rd_data,
    output logic                full,
    output logic                empty,
    output logic [ADDR_LEN:0]   level,
    output logic                overflow,
    output logic [15:0]         ovf_cnt
);

    localparam int DEPTH = 1 << ADDR_LEN;
    localparam logic [ADDR_LEN:0]   LEVEL_FULL = (ADDR_LEN + 1)'(DEPTH);
    localparam logic [ADDR_LEN:0]   LEVEL_ONE  = (ADDR_LEN + 1)'(1);
    localparam logic [ADDR_LEN-1:0] PTR_ONE    = ADDR_LEN'(1);

    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [ADDR_LEN-1:0] wr_ptr;
    logic [ADDR_LEN-1:0] rd_ptr;
    logic [ADDR_LEN:0]   level_next;
    logic                wr_accept;
    logic                drop;
    logic                fetch;

    // A full memory drops the incoming word even if a fetch frees a slot on the same edge.
    assign wr_accept = wr_en & ~full;
    assign drop      = wr_en & full;
    assign fetch     = ~empty & (~rd_valid | rd_ready);

    always_comb begin
        level_next = level;
        if (wr_accept && !fetch) begin
            level_next = level + LEVEL_ONE;
        end else if (!wr_accept && fetch) begin
            level_next = level - LEVEL_ONE;
        end
    end

    // Storage is not reset; stale contents are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (fetch) begin
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
                rd_ptr   <= rd_ptr + PTR_ONE;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
            level <= level_next;
            full  <= (level_next == LEVEL_FULL);
            empty <= (level_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef SAMPLE_FIFO_OVF_CNT_EN
    // A drop coinciding with the clear restarts the count at one rather than zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (clr_ovf) begin
            ovf_cnt <= drop ? 16'd1 : 16'd0;
        end else if (drop && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`else
    assign ovf_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// tb/tb_sample_fifo.sv - table-driven and sequence checks for sample_fifo (ADDR_LEN=4)
module tb_sample_fifo;

`ifdef SAMPLE_FIFO_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_ready;
    logic        clr_ovf;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] ovf_cnt;

    int checks = 0;
    int errors = 0;

    sample_fifo #(.DATA_LEN(32), .ADDR_LEN(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_ready (rd_ready),
        .clr_ovf  (clr_ovf),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [31:0] wr_data;
        logic        rd_ready;
        logic        clr_ovf;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_data;
        logic [4:0]  e_level;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int n);
        return CNT_EN ? 16'(n) : 16'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_idx;

        vecs[0] = '{1'b1, 32'h11223344, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        5'd1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h11223344, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h11223344, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h55,       1'b0, 1'b0, 1'b1, 1'b1, 32'h11223344, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h66,       1'b1, 1'b0, 1'b1, 1'b1, 32'h55,       5'd1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h66,       5'd0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b0};

        // Reset values while rst_n is held low
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;
        step();
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        rst_n = 1'b1;

        // Single-word latency and basic handshake vectors
        for (int i = 0; i < 8; i++) begin
            wr_en    = vecs[i].wr_en;
            wr_data  = vecs[i].wr_data;
            rd_ready = vecs[i].rd_ready;
            clr_ovf  = vecs[i].clr_ovf;
            step();
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            if (vecs[i].chk_data) check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_data);
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
        end
        wr_en = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;

        // Fill to total capacity, then one dropped word, then drain in order
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 32'(i);
            step();
        end
        wr_en = 1'b0;
        check("fill_rd_valid", 32'(rd_valid), 32'd1);
        check("fill_rd_data", rd_data, 32'h0);
        check("fill_level", 32'(level), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd0);
        wr_en = 1'b1; wr_data = 32'hDEAD;
        step();
        wr_en = 1'b0;
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_ovf_cnt", 32'(ovf_cnt), 32'(exp_cnt(1)));
        check("drop_level", 32'(level), 32'd16);
        rd_ready = 1'b1;
        exp_idx = 0;
        for (int c = 0; c < 25; c++) begin
            if (rd_valid) begin
                check("drain_order", rd_data, 32'(exp_idx));
                exp_idx++;
            end
            step();
        end
        check("drain_count", 32'(exp_idx), 32'd17);
        check("drain_rd_valid", 32'(rd_valid), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);

        // Overflow clear racing a drop
        rd_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 32'h200 + 32'(i);
            step();
        end
        check("refill_full", 32'(full), 32'd1);
        step();
        check("second_drop_cnt", 32'(ovf_cnt), 32'(exp_cnt(2)));
        clr_ovf = 1'b1;
        step();
        wr_en = 1'b0;
        check("clr_drop_overflow", 32'(overflow), 32'd1);
        check("clr_drop_cnt", 32'(ovf_cnt), 32'(exp_cnt(1)));
        step();
        clr_ovf = 1'b0;
        check("clr_only_overflow", 32'(overflow), 32'd0);
        check("clr_only_cnt", 32'(ovf_cnt), 32'd0);

        // Sustained streaming across pointer wrap
        do_reset();
        rd_ready = 1'b1;
        exp_idx = 0;
        for (int i = 0; i < 60; i++) begin
            wr_en   = (i < 40);
            wr_data = 32'h100 + 32'(i);
            step();
            check("stream_level_le1", 32'(level <= 5'd1), 32'd1);
            if (rd_valid) begin
                check("stream_order", rd_data, 32'h100 + 32'(exp_idx));
                exp_idx++;
            end
        end
        check("stream_count", 32'(exp_idx), 32'd40);
        check("stream_overflow", 32'(overflow), 32'd0);
        check("stream_empty", 32'(empty), 32'd1);

        // Asynchronous reset with words stored
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 32'h300 + 32'(i);
            step();
        end
        wr_en = 1'b0;
        check("pre_rst_level", 32'(level), 32'd9);
        rst_n = 1'b0;
        #2;
        check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        rst_n = 1'b1;
        wr_en = 1'b1; wr_data = 32'hA5A5A5A5;
        step();
        wr_en = 1'b0;
        check("post_rst_level", 32'(level), 32'd1);
        check("post_rst_rd_valid0", 32'(rd_valid), 32'd0);
        step();
        check("post_rst_rd_valid1", 32'(rd_valid), 32'd1);
        check("post_rst_rd_data", rd_data, 32'hA5A5A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 The block SHALL provide parameter DATA_LEN, default 32, giving the word width in bits.
REQ-002 The block SHALL provide parameter ADDR_LEN, default 9, so that memory depth is 2^ADDR_LEN words.
REQ-003 clk  input  1  clock; all logic SHALL be rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write strobe from the 8-to-32 packer (its valid_o); there is no backpressure.
REQ-006 wr_data  input  DATA_LEN  packed sample word.
REQ-007 rd_ready  input  1  downstream (USB bridge) accepts rd_data this cycle.
REQ-008 clr_ovf  input  1  one-cycle pulse that clears the overflow status.
REQ-009 rd_valid  output  1  rd_data holds a valid word.
REQ-010 rd_data  output  DATA_LEN  output word, registered.
REQ-011 full  output  1  memory level equals 2^ADDR_LEN.
REQ-012 empty  output  1  memory level equals 0 (excludes the output register).
REQ-013 level  output  ADDR_LEN+1  number of words in memory, excluding the output register.
REQ-014 overflow  output  1  sticky flag: at least one word was dropped.
REQ-015 ovf_cnt  output  16  count of dropped words.

Function
REQ-016 Storage SHALL be a dual-pointer circular buffer: write pointer and read pointer each ADDR_LEN bits, wrapping from 2^ADDR_LEN-1 to 0.
REQ-017 A write SHALL be accepted when wr_en=1 and full=0 at the clock edge: store at wr_ptr, wr_ptr+1.
REQ-018 When wr_en=1 and full=1, the word SHALL be dropped; memory and pointers are unchanged.
REQ-019 A dropped word SHALL set overflow, even if a pop frees space in the same cycle.
REQ-020 A fetch SHALL occur when level!=0 and (rd_valid=0 or rd_ready=1): mem[rd_ptr] is registered into rd_data, rd_valid<=1, rd_ptr+1.
REQ-021 When rd_valid=1, rd_ready=1 and level=0, rd_valid SHALL deassert on the next edge.
REQ-022 rd_data SHALL hold its value while rd_valid=1 and rd_ready=0.
REQ-023 level SHALL equal the previous level, plus 1 for an accepted write, minus 1 for a fetch; a simultaneous write and fetch SHALL leave it unchanged.
REQ-024 full and empty SHALL be registered, consistent with level in the same cycle.
REQ-025 Latency SHALL be exactly 2 edges from a write into an empty block (rd_valid=0) to rd_valid=1.
REQ-026 Sustained throughput SHALL be one word per clock when wr_en and rd_ready are held high.
REQ-027 Total capacity SHALL be 2^ADDR_LEN+1 words: memory plus the output register.
REQ-028 When clr_ovf=1, overflow and ovf_cnt SHALL clear on that edge, except when a drop occurs on the same edge; then overflow=1 and ovf_cnt=1.
REQ-029 Word order SHALL be preserved across pointer wrap-around.

Reset
REQ-030 While rst_n=0, the block SHALL hold: pointers=0, level=0, empty=1, full=0, rd_valid=0, rd_data=0, overflow=0, ovf_cnt=0.
REQ-031 A reset mid-operation SHALL discard all stored words; memory contents need not be cleared.
REQ-032 The first write SHALL be accepted on the first edge after rst_n deasserts.

Configuration
REQ-033 With macro SAMPLE_FIFO_OVF_CNT_EN defined, ovf_cnt SHALL increment per dropped word, saturate at 0xFFFF, and clear per REQ-028.
REQ-034 Without SAMPLE_FIFO_OVF_CNT_EN, ovf_cnt SHALL be constant 0 and no counter register shall be implemented; the overflow flag remains.

Verification (ADDR_LEN=4, macro defined)
REQ-035 After reset, a single write of 0x11223344 with rd_ready=0 -> rd_valid=1 after 2 edges, rd_data=0x11223344, level=0, empty=1.
REQ-036 17 writes 0x0..0x10 with rd_ready=0 -> rd_valid=1, rd_data=0x0, level=16, full=1, overflow=0.
REQ-037 An 18th write of 0xDEAD with rd_ready=0 -> dropped, overflow=1, ovf_cnt=1; after draining, output order is 0x0..0x10 with no 0xDEAD.
REQ-038 40 writes while rd_ready=1 continuously -> every word is read in order, level<=1, no overflow, and pointers wrap correctly.
REQ-039 clr_ovf on the same edge as a drop -> overflow=1, ovf_cnt=1; clr_ovf alone on the next edge -> both 0.
REQ-040 rst_n pulsed low while 10 words are stored -> rd_valid=0, level=0, empty=1, ovf_cnt=0 immediately; a subsequent write of 0xA5A5A5A5 is read out first.
